// File: rtl/axi_pkg.sv
// Shared definitions for the AXI slave: default widths, burst and response
// codes, FSM state encodings and the per-beat address update helper.
package axi_pkg;

  localparam int AXI_ID_BITS    = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_LEN_BITS   = 8;
  localparam int AXI_SIZE_BITS  = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RD   = 2'd1,
    R_WAIT = 2'd2,
    R_DATA = 2'd3
  } r_state_e;

  // Next beat address. Computed at 64 bits so any address width can use it;
  // the caller truncates, which gives the modulo-2^ADDR_WIDTH wrap for free.
  // Beats are always 4 bytes wide; FIXED (and anything that is not INCR) holds.
  function automatic logic [63:0] axi_addr_next(input logic [63:0] addr,
                                                input logic [1:0]  burst);
    if (burst == BURST_INCR) return addr + 64'd4;
    else                     return addr;
  endfunction

endpackage

// File: rtl/axi_interface_slave.sv
// AXI slave front-end onto a simple single-port memory. Independent write and
// read FSMs share the memory port; an active write beat always wins the port.
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where both valid and ready are 1. The master holds valid and payload steady
// until that edge; the slave drives ready purely from its own state (plus the
// port arbitration for reads), and bvalid/rvalid stay high with stable payload
// until the matching ready is seen.
module axi_interface_slave
  import axi_pkg::*;
#(
  parameter int ID_BITS    = AXI_ID_BITS,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int LEN_BITS   = AXI_LEN_BITS,
  parameter int SIZE_BITS  = AXI_SIZE_BITS,
  parameter int MAX_LEN    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // AW
  input  logic [ID_BITS-1:0]      awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [LEN_BITS-1:0]     awlen_i,
  input  logic [SIZE_BITS-1:0]    awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  // W
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  // B
  output logic [ID_BITS-1:0]      bid_o,
  output logic [2:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  // AR
  input  logic [ID_BITS-1:0]      arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [LEN_BITS-1:0]     arlen_i,
  input  logic [SIZE_BITS-1:0]    arsize_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  // R
  output logic [ID_BITS-1:0]      rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [2:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  // Memory port (byte address, read data valid one cycle after mem_re_o)
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  output logic                    mem_we_o,
  output logic                    mem_re_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  // FSM state visibility
  output logic [1:0]              wstate_dbg_o,
  output logic [1:0]              rstate_dbg_o
);

  localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_LEN);

  // Write side state
  w_state_e              r_wstate;
  logic [ID_BITS-1:0]    r_awid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [LEN_BITS-1:0]   r_wlen;
  logic [LEN_BITS-1:0]   r_wcnt;
  logic [1:0]            r_wburst;
  logic                  r_wbad;    // unsupported burst type or length
  logic                  r_wmis;    // an earlier beat had wlast in the wrong place
  logic [2:0]            r_bresp;

  // Read side state
  r_state_e              r_rstate;
  logic [ID_BITS-1:0]    r_arid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [LEN_BITS-1:0]   r_rlen;
  logic [LEN_BITS-1:0]   r_rcnt;
  logic [1:0]            r_rburst;
  logic                  r_rbad;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic w_aw_bad, w_ar_bad;
  logic w_wlast_ok;
  logic w_wr_own, w_rd_grant, w_rd_issue;
  logic w_rlast;
  logic w_unused;

  // Transfer size is not used: every beat is a 4-byte word.
  assign w_unused = ^{awsize_i, arsize_i};

  assign awready_o = (r_wstate == W_IDLE);
  assign wready_o  = (r_wstate == W_DATA);
  assign bvalid_o  = (r_wstate == W_RESP);
  assign bid_o     = r_awid;
  assign bresp_o   = r_bresp;

  assign arready_o = (r_rstate == R_IDLE);
  assign rvalid_o  = (r_rstate == R_DATA);
  assign w_rlast   = (r_rcnt == r_rlen);
  assign rlast_o   = rvalid_o && w_rlast;
  assign rid_o     = r_arid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = (rvalid_o && r_rbad) ? RESP_SLVERR : RESP_OKAY;

  assign w_aw_hs = awvalid_i && awready_o;
  assign w_w_hs  = wvalid_i && wready_o;
  assign w_ar_hs = arvalid_i && arready_o;
  assign w_r_hs  = rready_i && rvalid_o;

  assign w_aw_bad = (awburst_i == BURST_WRAP) || (awburst_i == 2'b11) || (awlen_i > MAX_LEN_L);
  assign w_ar_bad = (arburst_i == BURST_WRAP) || (arburst_i == 2'b11) || (arlen_i > MAX_LEN_L);

  // wlast must appear exactly on the beat whose count equals the burst length.
  assign w_wlast_ok = (wlast_i == (r_wcnt == r_wlen));

  // A presented write beat owns the memory port; reads only use idle cycles.
  assign w_wr_own   = (r_wstate == W_DATA) && wvalid_i;
  assign w_rd_grant = !w_wr_own;
  assign w_rd_issue = (r_rstate == R_RD) && !r_rbad && w_rd_grant;

  assign wstate_dbg_o = r_wstate;
  assign rstate_dbg_o = r_rstate;

  // Write FSM: accept address, stream beats into memory, then hold response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate <= W_IDLE;
      r_awid   <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wburst <= BURST_FIXED;
      r_wbad   <= 1'b0;
      r_wmis   <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awid   <= awid_i;
            r_waddr  <= awaddr_i;
            r_wlen   <= awlen_i;
            r_wburst <= awburst_i;
            r_wcnt   <= '0;
            r_wbad   <= w_aw_bad;
            r_wmis   <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_waddr <= ADDR_WIDTH'(axi_addr_next(64'(r_waddr), r_wburst));
            // Counter saturates at len so an overlong burst cannot wrap it.
            if (r_wcnt != r_wlen) r_wcnt <= r_wcnt + 1'b1;
            if (!w_wlast_ok) r_wmis <= 1'b1;
            if (wlast_i) begin
              r_bresp  <= (r_wbad || r_wmis || !w_wlast_ok) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready_i) begin
            r_bresp  <= RESP_OKAY;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: one memory read per beat (issue, wait, present), three cycles minimum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_arid   <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rburst <= BURST_FIXED;
      r_rbad   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arid   <= arid_i;
            r_raddr  <= araddr_i;
            r_rlen   <= arlen_i;
            r_rburst <= arburst_i;
            r_rcnt   <= '0;
            r_rbad   <= w_ar_bad;
            r_rstate <= R_RD;
          end
        end
        R_RD: begin
          // Error bursts never touch memory, so they need no grant.
          if (r_rbad || w_rd_grant) r_rstate <= R_WAIT;
        end
        R_WAIT: begin
          r_rdata  <= r_rbad ? '0 : mem_rdata_i;
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (w_rlast) begin
              r_rstate <= R_IDLE;
            end else begin
              r_raddr  <= ADDR_WIDTH'(axi_addr_next(64'(r_raddr), r_rburst));
              r_rcnt   <= r_rcnt + 1'b1;
              r_rstate <= R_RD;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Memory port mux: write beat first, then a granted read, otherwise all zero.
  // Strobes are also blocked while reset is held so a reset edge never writes.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    if (!rst_i) begin
      if (w_wr_own) begin
        if (!r_wbad) begin
          mem_addr_o  = r_waddr;
          mem_wdata_o = wdata_i;
          mem_wstrb_o = wstrb_i;
          mem_we_o    = 1'b1;
        end
      end else if (w_rd_issue) begin
        mem_addr_o = r_raddr;
        mem_re_o   = 1'b1;
      end
    end
  end

endmodule
